// File: rtl/hazard_stall_ctrl_if.sv
// hazard_stall_ctrl_if: ID/EX/MEM hazard inputs and stall/flush/counter outputs of the hazard controller
// master: pipeline side (drives hazard inputs); slave: hazard_stall_ctrl (drives stall/flush/counters)
interface hazard_stall_ctrl_if #(
  parameter int ADDRESS_PORT_WIDTH = 5,
  parameter int CNT_WIDTH = 32
);
  logic [ADDRESS_PORT_WIDTH-1:0] ID_RS1, ID_RS2, ID_EX_RD, EX_MEM_RD;
  logic ID_UsesRS1, ID_UsesRS2, ID_IsBranch, BranchTaken;
  logic ID_EX_RegWrite, ID_EX_MemRead, EX_MEM_MemRead;
  logic PC_Write, IF_ID_Write, ID_EX_Bubble, IF_ID_Flush;
  logic [CNT_WIDTH-1:0] StallCycles, FlushCount;
  modport master(
    output ID_RS1, ID_RS2, ID_EX_RD, EX_MEM_RD, ID_UsesRS1, ID_UsesRS2, ID_IsBranch, BranchTaken,
           ID_EX_RegWrite, ID_EX_MemRead, EX_MEM_MemRead,
    input  PC_Write, IF_ID_Write, ID_EX_Bubble, IF_ID_Flush, StallCycles, FlushCount
  );
  modport slave(
    input  ID_RS1, ID_RS2, ID_EX_RD, EX_MEM_RD, ID_UsesRS1, ID_UsesRS2, ID_IsBranch, BranchTaken,
           ID_EX_RegWrite, ID_EX_MemRead, EX_MEM_MemRead,
    output PC_Write, IF_ID_Write, ID_EX_Bubble, IF_ID_Flush, StallCycles, FlushCount
  );
endinterface

// File: rtl/hazard_stall_ctrl.sv
// hazard_stall_ctrl: ID-stage load-use / branch-operand stall and branch flush control with saturating perf counters
// clk, reset (sync, active-high); bus (slave): ID sources, EX/MEM producers in; PC/IF_ID/ID_EX controls and counters out
module hazard_stall_ctrl #(
  parameter int ADDRESS_PORT_WIDTH = 5,
  parameter int CNT_WIDTH = 32
) (
  input logic clk,
  input logic reset,
  hazard_stall_ctrl_if.slave bus
);
  typedef enum logic {RUN, HOLD} state_t;
  localparam logic [ADDRESS_PORT_WIDTH-1:0] X0 = '0;
  state_t state, nextState;
  logic rem, nextRem;
  logic hitEx, hitMem, loadUse, brLoadEx, brLoadMem, stall;
  logic [CNT_WIDTH-1:0] stallCycles, flushCount;
  // x0 is hardwired zero, so a producer targeting it never creates a dependency
  assign hitEx = (bus.ID_UsesRS1 && bus.ID_RS1 == bus.ID_EX_RD ||
                  bus.ID_UsesRS2 && bus.ID_RS2 == bus.ID_EX_RD) && bus.ID_EX_RD != X0;
  assign hitMem = (bus.ID_UsesRS1 && bus.ID_RS1 == bus.EX_MEM_RD ||
                   bus.ID_UsesRS2 && bus.ID_RS2 == bus.EX_MEM_RD) && bus.EX_MEM_RD != X0;
  // ALU producers in EX are forwarded into ID, so only loads stall a branch
  assign loadUse = bus.ID_EX_MemRead && hitEx;
  assign brLoadEx = bus.ID_IsBranch && loadUse;
  assign brLoadMem = bus.ID_IsBranch && bus.EX_MEM_MemRead && hitMem;
  always_comb begin
    nextState = state;
    nextRem = rem;
    stall = 1'b0;
    if (state == HOLD) begin
      stall = 1'b1;
      nextState = rem ? HOLD : RUN;
      nextRem = rem ? 1'b0 : rem;
    end else if (brLoadEx) begin
      stall = 1'b1;
      nextState = HOLD;
      nextRem = 1'b0;
    end else if (loadUse || brLoadMem) begin
      stall = 1'b1;
    end
    if (reset) begin
      stall = 1'b0;
      nextState = RUN;
      nextRem = 1'b0;
    end
  end
  // an unresolved branch cannot redirect, so a stall masks BranchTaken
  assign bus.PC_Write = !stall;
  assign bus.IF_ID_Write = !stall;
  assign bus.ID_EX_Bubble = stall;
  assign bus.IF_ID_Flush = !reset && !stall && bus.BranchTaken;
  assign bus.StallCycles = stallCycles;
  assign bus.FlushCount = flushCount;
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= RUN;
      rem <= 1'b0;
      stallCycles <= '0;
      flushCount <= '0;
    end else begin
      state <= nextState;
      rem <= nextRem;
      if (stall && !(&stallCycles)) stallCycles <= stallCycles + CNT_WIDTH'(1);
      if (bus.IF_ID_Flush && !(&flushCount)) flushCount <= flushCount + CNT_WIDTH'(1);
    end
  end
endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// tb_hazard_stall_ctrl: directed-vector scoreboard bench for hazard_stall_ctrl (CNT_WIDTH=4 to reach saturation)
module tb_hazard_stall_ctrl;
  localparam int AW = 5;
  localparam int CW = 4;
  typedef struct {
    string name;
    logic [3:0] outs;
    logic chk;
    logic [CW-1:0] sc;
    logic [CW-1:0] fc;
  } exp_t;
  logic clk = 1'b0;
  logic reset;
  exp_t sbq[$];
  int compared = 0;
  int mismatched = 0;
  bit done = 1'b0;
  hazard_stall_ctrl_if #(.ADDRESS_PORT_WIDTH(AW), .CNT_WIDTH(CW)) bus();
  hazard_stall_ctrl #(.ADDRESS_PORT_WIDTH(AW), .CNT_WIDTH(CW)) dut(.clk(clk), .reset(reset), .bus(bus.slave));
  always #5 clk = ~clk;
  // drive one cycle of inputs just after the edge and queue the hand-computed response for that cycle
  task automatic step(input string nm, input logic rst, input logic br, input logic bt,
                      input logic u1, input logic u2, input logic [AW-1:0] rs1, input logic [AW-1:0] rs2,
                      input logic [AW-1:0] exrd, input logic [AW-1:0] mrd,
                      input logic exrw, input logic exmr, input logic mmr,
                      input logic s, input logic f, input logic chk,
                      input logic [CW-1:0] sc, input logic [CW-1:0] fc);
    exp_t e;
    @(posedge clk);
    #1;
    reset = rst;
    bus.ID_IsBranch = br;
    bus.BranchTaken = bt;
    bus.ID_UsesRS1 = u1;
    bus.ID_UsesRS2 = u2;
    bus.ID_RS1 = rs1;
    bus.ID_RS2 = rs2;
    bus.ID_EX_RD = exrd;
    bus.EX_MEM_RD = mrd;
    bus.ID_EX_RegWrite = exrw;
    bus.ID_EX_MemRead = exmr;
    bus.EX_MEM_MemRead = mmr;
    e.name = nm;
    e.outs = {!s, !s, s, f};
    e.chk = chk;
    e.sc = sc;
    e.fc = fc;
    sbq.push_back(e);
  endtask
  initial begin
    exp_t e;
    logic [3:0] got;
    forever begin
      @(negedge clk);
      if (sbq.size() > 0) begin
        e = sbq.pop_front();
        got = {bus.PC_Write, bus.IF_ID_Write, bus.ID_EX_Bubble, bus.IF_ID_Flush};
        compared++;
        if (got !== e.outs) begin
          mismatched++;
          $display("FAIL %s ctrl {PCW,IFW,BUB,FLUSH}: got %b want %b", e.name, got, e.outs);
        end
        if (e.chk) begin
          compared++;
          if (bus.StallCycles !== e.sc || bus.FlushCount !== e.fc) begin
            mismatched++;
            $display("FAIL %s counters: got stall=%0d flush=%0d want stall=%0d flush=%0d",
                     e.name, bus.StallCycles, bus.FlushCount, e.sc, e.fc);
          end
        end
      end
    end
  end
  initial begin
    logic [CW-1:0] exp_sc;
    reset = 1'b1;
    bus.ID_IsBranch = 0; bus.BranchTaken = 0; bus.ID_UsesRS1 = 0; bus.ID_UsesRS2 = 0;
    bus.ID_RS1 = 0; bus.ID_RS2 = 0; bus.ID_EX_RD = 0; bus.EX_MEM_RD = 0;
    bus.ID_EX_RegWrite = 0; bus.ID_EX_MemRead = 0; bus.EX_MEM_MemRead = 0;
    //     name        rst br bt u1 u2 rs1 rs2 exrd mrd exrw exmr mmr  s  f chk sc fc
    step("rst_out",     1, 0, 1, 0, 0, 0,  0,  0,   0,  0,   0,   0,   0, 0, 0, 0, 0);
    step("rst_cnt",     1, 0, 0, 0, 0, 0,  0,  0,   0,  0,   0,   0,   0, 0, 1, 0, 0);
    step("idle",        0, 0, 0, 0, 0, 0,  0,  0,   0,  0,   0,   0,   0, 0, 1, 0, 0);
    step("load_use",    0, 0, 0, 0, 1, 0,  5,  5,   0,  1,   1,   0,   1, 0, 1, 0, 0);
    step("lu_after",    0, 0, 0, 0, 0, 0,  0,  0,   0,  0,   0,   0,   0, 0, 1, 1, 0);
    step("brlex_det",   0, 1, 0, 1, 0, 7,  0,  7,   0,  1,   1,   0,   1, 0, 1, 1, 0);
    step("brlex_hold",  0, 0, 0, 0, 0, 0,  0,  0,   0,  0,   0,   0,   1, 0, 1, 2, 0);
    step("brlex_after", 0, 0, 0, 0, 0, 0,  0,  0,   0,  0,   0,   0,   0, 0, 1, 3, 0);
    step("alu_branch",  0, 1, 1, 1, 0, 3,  0,  3,   0,  1,   0,   0,   0, 1, 1, 3, 0);
    step("alu_after",   0, 0, 0, 0, 0, 0,  0,  0,   0,  0,   0,   0,   0, 0, 1, 3, 1);
    step("brlmem_mask", 0, 1, 1, 0, 1, 0,  9,  0,   9,  0,   0,   1,   1, 0, 1, 3, 1);
    step("brlmem_go",   0, 1, 1, 0, 1, 0,  9,  0,   9,  0,   0,   0,   0, 1, 1, 4, 1);
    step("brlmem_after",0, 0, 0, 0, 0, 0,  0,  0,   0,  0,   0,   0,   0, 0, 1, 4, 2);
    step("x0_load",     0, 0, 0, 1, 0, 0,  0,  0,   0,  0,   1,   0,   0, 0, 1, 4, 2);
    step("x0_mem_br",   0, 1, 0, 1, 0, 0,  0,  0,   0,  0,   0,   1,   0, 0, 1, 4, 2);
    step("unused_rs1",  0, 0, 0, 0, 0, 4,  0,  4,   0,  0,   1,   0,   0, 0, 1, 4, 2);
    step("b2b_1",       0, 0, 0, 1, 0, 6,  0,  6,   0,  0,   1,   0,   1, 0, 1, 4, 2);
    step("b2b_2",       0, 0, 0, 0, 1, 0,  8,  8,   0,  0,   1,   0,   1, 0, 1, 5, 2);
    step("b2b_after",   0, 0, 0, 0, 0, 0,  0,  0,   0,  0,   0,   0,   0, 0, 1, 6, 2);
    step("hold_det",    0, 1, 0, 1, 0, 7,  0,  7,   0,  0,   1,   0,   1, 0, 1, 6, 2);
    step("hold_reset",  1, 0, 1, 0, 0, 0,  0,  0,   0,  0,   0,   0,   0, 0, 1, 7, 2);
    step("post_reset",  0, 0, 0, 0, 0, 0,  0,  0,   0,  0,   0,   0,   0, 0, 1, 0, 0);
    for (int i = 0; i < 20; i++) begin
      exp_sc = (i > 15) ? 4'd15 : 4'(i);
      step("sat_stall", 0, 0, 0, 0, 1, 0, 5, 5, 0, 0, 1, 0, 1, 0, 1, exp_sc, 0);
    end
    step("sat_hold",    0, 0, 0, 0, 0, 0,  0,  0,   0,  0,   0,   0,   0, 0, 1, 15, 0);
    for (int i = 0; i < 5 && sbq.size() > 0; i++) @(negedge clk);
    @(negedge clk);
    if (sbq.size() > 0) begin
      mismatched++;
      $display("FAIL drain: %0d entries left, want 0", sbq.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
